// File: rtl/debouncer_array_if.sv
// debouncer_array_if: raw button pins and timebase strobe in, debounced levels and event strobes out.
// Latency: pure wiring bundle, no storage.
// Backpressure: none; every strobe is a single-cycle event the consumer must sample.
interface debouncer_array_if #(
   parameter int N_CH = 4
);
   logic            i_tick;       // shared timebase strobe
   logic [N_CH-1:0] i_btn;        // raw asynchronous pins, active-high
   logic [N_CH-1:0] o_debounced;  // filtered level per channel
   logic [N_CH-1:0] o_rise;       // accepted 0->1 transition
   logic [N_CH-1:0] o_fall;       // accepted 1->0 transition
   logic [N_CH-1:0] o_long;       // long-press reached
   logic [N_CH-1:0] o_repeat;     // auto-repeat while long-pressed

   // Button/timebase side: drives pins and tick, consumes events.
   modport master (
      output i_tick, i_btn,
      input  o_debounced, o_rise, o_fall, o_long, o_repeat
   );

   // Debouncer side.
   modport slave (
      input  i_tick, i_btn,
      output o_debounced, o_rise, o_fall, o_long, o_repeat
   );
endinterface

// File: rtl/debouncer_array.sv
// debouncer_array: N_CH independent button debouncers with press/release strobes, long-press and auto-repeat.
// Latency: o_debounced/o_rise 3 clocks after a pin change is first sampled (2-FF sync + acceptance register).
// Backpressure: none; outputs are registered single-cycle strobes, timers advance only on i_tick.
module debouncer_array #(
   parameter int N_CH         = 4,
   parameter int TIME_PERIOD  = 250,
   parameter int LONG_TICKS   = 12500,
   parameter int REPEAT_TICKS = 2500
) (
   input  logic              i_clk,
   input  logic              i_rst,
   debouncer_array_if.slave  bus
);

   localparam int TMR_W  = (TIME_PERIOD > 1) ? $clog2(TIME_PERIOD) : 1;
   localparam int HOLD_W = $clog2(LONG_TICKS + 1);

   localparam logic [TMR_W-1:0]  TMR_RELOAD = TMR_W'(TIME_PERIOD - 1);
   localparam logic [TMR_W-1:0]  TMR_ONE    = TMR_W'(1);
   localparam logic [HOLD_W-1:0] LONG_V     = HOLD_W'(LONG_TICKS);
   localparam logic [HOLD_W-1:0] LONG_M1    = HOLD_W'(LONG_TICKS - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

   // Two-stage synchroniser for the asynchronous pins.
   logic [N_CH-1:0] sync1_q;
   logic [N_CH-1:0] sync2_q;

   // Per-channel debounce and hold state.
   logic [N_CH-1:0]   deb_q,  deb_d;
   logic [N_CH-1:0]   rise_q, rise_d;
   logic [N_CH-1:0]   fall_q, fall_d;
   logic [N_CH-1:0]   long_q, long_d;
   logic [TMR_W-1:0]  timer_q [N_CH];
   logic [TMR_W-1:0]  timer_d [N_CH];
   logic [HOLD_W-1:0] hold_q  [N_CH];
   logic [HOLD_W-1:0] hold_d  [N_CH];

   // Channel accepts a new level this cycle; shared with the repeat logic.
   logic [N_CH-1:0]   accept;

   // Synchroniser runs every clock, independent of the timebase.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= bus.i_btn;
         sync2_q <= sync1_q;
      end
   end

   // Acceptance, lockout timer and long-press hold counter next-state.
   // An accepted transition takes priority over the hold increment, so a release
   // landing on the cycle the hold count would complete suppresses o_long.
   always_comb begin
      deb_d  = deb_q;
      rise_d = '0;
      fall_d = '0;
      long_d = '0;
      accept = '0;
      for (int k = 0; k < N_CH; k++) begin
         timer_d[k] = timer_q[k];
         hold_d[k]  = hold_q[k];
         if ((timer_q[k] == '0) && (sync2_q[k] != deb_q[k])) begin
            accept[k]  = 1'b1;
            deb_d[k]   = sync2_q[k];
            timer_d[k] = TMR_RELOAD;
            rise_d[k]  = sync2_q[k];
            fall_d[k]  = ~sync2_q[k];
            hold_d[k]  = '0;
         end else begin
            if ((timer_q[k] != '0) && bus.i_tick) begin
               timer_d[k] = timer_q[k] - TMR_ONE;
            end
            if (deb_q[k] && bus.i_tick && (hold_q[k] < LONG_V)) begin
               hold_d[k] = hold_q[k] + HOLD_ONE;
               long_d[k] = (hold_q[k] == LONG_M1);
            end
         end
      end
   end

   // Debounce state and event strobes register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         deb_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
         long_q <= '0;
         for (int k = 0; k < N_CH; k++) begin
            timer_q[k] <= '0;
            hold_q[k]  <= '0;
         end
      end else begin
         deb_q  <= deb_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         long_q <= long_d;
         for (int k = 0; k < N_CH; k++) begin
            timer_q[k] <= timer_d[k];
            hold_q[k]  <= hold_d[k];
         end
      end
   end

   assign bus.o_debounced = deb_q;
   assign bus.o_rise      = rise_q;
   assign bus.o_fall      = fall_q;
   assign bus.o_long      = long_q;

   if (REPEAT_TICKS > 0) begin : g_rep
      localparam int REP_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
      localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);
      localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

      logic [REP_W-1:0] rep_q [N_CH];
      logic [REP_W-1:0] rep_d [N_CH];
      logic [N_CH-1:0]  repeat_q, repeat_d;

      // Repeat counter only runs once the hold count has saturated; it restarts
      // on the o_long cycle and whenever the channel is released or re-accepted.
      always_comb begin
         repeat_d = '0;
         for (int k = 0; k < N_CH; k++) begin
            rep_d[k] = rep_q[k];
            if (accept[k] || long_d[k] || !deb_q[k]) begin
               rep_d[k] = '0;
            end else if ((hold_q[k] == LONG_V) && bus.i_tick) begin
               if (rep_q[k] == REP_LAST) begin
                  rep_d[k]    = '0;
                  repeat_d[k] = 1'b1;
               end else begin
                  rep_d[k] = rep_q[k] + REP_ONE;
               end
            end
         end
      end

      // Repeat counter and strobe register.
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            repeat_q <= '0;
            for (int k = 0; k < N_CH; k++) begin
               rep_q[k] <= '0;
            end
         end else begin
            repeat_q <= repeat_d;
            for (int k = 0; k < N_CH; k++) begin
               rep_q[k] <= rep_d[k];
            end
         end
      end

      assign bus.o_repeat = repeat_q;
   end else begin : g_no_rep
      assign bus.o_repeat = '0;
   end

endmodule

// File: tb/tb_debouncer_array.sv
// tb_debouncer_array: directed scenarios with hand-derived event cycles for a 2-channel debouncer.
// Latency: step s below means the s-th rising edge of a scenario; outputs are sampled 1ns after it.
// Backpressure: none; each step compares all five output vectors against expected values.
module tb_debouncer_array;

   logic i_clk;
   logic i_rst;
   int   n_checks;
   int   n_err;

   debouncer_array_if #(.N_CH(2)) bus ();

   debouncer_array #(
      .N_CH        (2),
      .TIME_PERIOD (4),
      .LONG_TICKS  (10),
      .REPEAT_TICKS(3)
   ) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .bus  (bus)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string sc, input int s, input logic [1:0] d,
                             input logic [1:0] r, input logic [1:0] f,
                             input logic [1:0] l, input logic [1:0] p);
      chk($sformatf("%s.s%0d.deb", sc, s), bus.o_debounced, d);
      chk($sformatf("%s.s%0d.rise", sc, s), bus.o_rise, r);
      chk($sformatf("%s.s%0d.fall", sc, s), bus.o_fall, f);
      chk($sformatf("%s.s%0d.long", sc, s), bus.o_long, l);
      chk($sformatf("%s.s%0d.rep", sc, s), bus.o_repeat, p);
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      n_checks   = 0;
      n_err      = 0;
      i_rst      = 1'b1;
      bus.i_tick = 1'b1;
      bus.i_btn  = 2'b11;

      // Reset held 5 cycles with both buttons pressed: everything stays 0.
      for (int s = 1; s <= 5; s++) begin
         step();
         check_outs("rst_hold", s, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      end
      i_rst = 1'b0;

      // Both channels accepted on the 3rd edge after reset drops; released after step 4,
      // release accepted once the lockout (reload at 3, zero after 6) has expired.
      for (int s = 1; s <= 8; s++) begin
         step();
         check_outs("rst_rel", s, {2{s >= 3 && s < 7}}, {2{s == 3}}, {2{s == 7}}, 2'b00, 2'b00);
         if (s == 4) bus.i_btn = 2'b00;
      end
      idle(5);

      // Ch0 press, pin low for samples 2..3 (inside lockout), release after step 8.
      bus.i_btn = 2'b01;
      for (int s = 1; s <= 13; s++) begin
         step();
         check_outs("glitch", s, {1'b0, s >= 3 && s < 11}, {1'b0, s == 3}, {1'b0, s == 11}, 2'b00, 2'b00);
         if (s == 1) bus.i_btn = 2'b00;
         if (s == 3) bus.i_btn = 2'b01;
         if (s == 8) bus.i_btn = 2'b00;
      end
      idle(5);

      // Ch0 long hold: o_long 10 after o_rise, o_repeat every 3 after o_long, release after step 32.
      bus.i_btn = 2'b01;
      for (int s = 1; s <= 36; s++) begin
         step();
         check_outs("long", s, {1'b0, s >= 3 && s < 35}, {1'b0, s == 3}, {1'b0, s == 35},
                    {1'b0, s == 13}, {1'b0, s > 13 && s < 35 && ((s - 13) % 3 == 0)});
         if (s == 32) bus.i_btn = 2'b00;
      end
      idle(5);

      // Release accepted on the edge the hold count would have reached 10: no o_long.
      bus.i_btn = 2'b01;
      for (int s = 1; s <= 15; s++) begin
         step();
         check_outs("collide", s, {1'b0, s >= 3 && s < 13}, {1'b0, s == 3}, {1'b0, s == 13}, 2'b00, 2'b00);
         if (s == 10) bus.i_btn = 2'b00;
      end

      // Re-press gives a fresh count.
      bus.i_btn = 2'b01;
      for (int s = 1; s <= 18; s++) begin
         step();
         check_outs("repress", s, {1'b0, s >= 3 && s < 17}, {1'b0, s == 3}, {1'b0, s == 17},
                    {1'b0, s == 13}, {1'b0, s == 16});
         if (s == 14) bus.i_btn = 2'b00;
      end
      idle(5);

      // Tick 1 in 4 (edges 4,8,...): ch0 long at 40, repeat at 52; ch1 pressed and released
      // early but its release is held off by the scaled lockout until edge 21.
      bus.i_btn  = 2'b01;
      bus.i_tick = 1'b0;
      for (int s = 1; s <= 58; s++) begin
         step();
         check_outs("tick4", s, {s >= 8 && s < 21, s >= 3 && s < 57}, {s == 8, s == 3},
                    {s == 21, s == 57}, {1'b0, s == 40}, {1'b0, s == 52});
         bus.i_tick = ((s + 1) % 4 == 0);
         if (s == 5)  bus.i_btn[1] = 1'b1;
         if (s == 10) bus.i_btn[1] = 1'b0;
         if (s == 54) bus.i_btn[0] = 1'b0;
      end
      bus.i_tick = 1'b1;
      idle(6);

      // One-cycle reset during ch1 lockout/hold: state cleared, press re-accepted and re-timed.
      bus.i_btn = 2'b10;
      for (int s = 1; s <= 21; s++) begin
         step();
         check_outs("midrst", s, {(s >= 3 && s < 5) || s >= 8, 1'b0}, {s == 3 || s == 8, 1'b0},
                    2'b00, {s == 18, 1'b0}, {s == 21, 1'b0});
         if (s == 4) i_rst = 1'b1;
         if (s == 5) i_rst = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/debouncer_array.md
Name: debouncer_array

Overview:
- Multi-channel, parametrised successor to the single-button debouncer.
- Each channel has:
  - a 2-FF synchroniser
  - a lockout-timer debouncer
  - one-cycle press (rise) and release (fall) strobes
  - long-press detection, with optional auto-repeat
- Timers advance only on a shared tick-enable strobe, so the block runs from the fast system clock.
- Sits between raw push-button pins and the clock-setting FSM (set/increment buttons).

Parameters:
N_CH, 4, number of independent button channels (>=1)
TIME_PERIOD, 250, lockout length in i_tick strobes after each accepted transition (>=1)
LONG_TICKS, 12500, i_tick strobes of continuous debounced-high before o_long fires (>=2)
REPEAT_TICKS, 2500, i_tick strobes between o_repeat pulses after o_long; 0 disables auto-repeat
(localparams: TMR_W = clog2(TIME_PERIOD), min 1; HOLD_W = clog2(LONG_TICKS+1); REP_W = clog2(REPEAT_TICKS), min 1)

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset; synchronous, active-high
i_tick  in  1  timebase strobe; timers/counters advance only when high
i_btn  in  N_CH  raw asynchronous button inputs, active-high
o_debounced  out  N_CH  debounced level per channel
o_rise  out  N_CH  one-cycle pulse when o_debounced[k] goes 0->1
o_fall  out  N_CH  one-cycle pulse when o_debounced[k] goes 1->0
o_long  out  N_CH  one-cycle pulse when held LONG_TICKS ticks
o_repeat  out  N_CH  one-cycle pulse every REPEAT_TICKS ticks after o_long while held

Behaviour:
- Reset: sync FFs, timers, hold/repeat counters and all outputs go to 0 on the edge where i_rst=1. Reset mid-operation discards all in-flight state. A button still held after reset is re-accepted as a fresh press: o_rise fires and the long-press count restarts.
- Channels are fully independent; no shared state except i_tick.
- Synchroniser: sync1[k]<=i_btn[k]; sync2[k]<=sync1[k] every clock, regardless of i_tick.
- Acceptance, per clock:
  - If timer[k]==0 and sync2[k]!=o_debounced[k]:
    - o_debounced[k]<=sync2[k]
    - timer[k]<=TIME_PERIOD-1
    - o_rise[k] or o_fall[k]=1 for that cycle
  - Else, if timer[k]!=0 and i_tick, timer[k] decrements.
- Latency: with timer idle, o_debounced rises on the 3rd rising edge at which i_btn is sampled high. o_rise is asserted in the same cycle o_debounced first reads 1.
- Lockout:
  - Input changes while timer!=0 are ignored.
  - If sync2 differs from o_debounced in the first cycle timer==0, the change is accepted that cycle.
  - So a glitch that outlasts the lockout is accepted; a glitch that ends inside it is not.
- o_rise/o_fall: never both high; deasserted the following cycle.
- Hold counter:
  - Cleared on any accepted transition.
  - While o_debounced[k]==1 and i_tick and hold[k]<LONG_TICKS: hold[k]++.
  - The cycle hold reaches LONG_TICKS: o_long[k]=1 for one cycle, then hold saturates. No further o_long until release and re-press.
- Repeat counter (REPEAT_TICKS>0 only):
  - Cleared when o_long fires.
  - While saturated and held: counts i_tick. On reaching REPEAT_TICKS-1 with i_tick, it fires o_repeat[k] for one cycle and wraps to 0.
  - Cleared on release.
- REPEAT_TICKS==0: o_repeat tied 0; repeat logic optimised away.
- A release accepted in the same cycle hold would have reached LONG_TICKS: acceptance wins. No o_long is emitted and hold clears.
- i_tick held 0: timers and counters freeze. Synchroniser and acceptance when timer==0 still operate.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan (N_CH=2, TIME_PERIOD=4, LONG_TICKS=10, REPEAT_TICKS=3, i_tick=1 unless noted):
- Reset held 5 cycles with i_btn=2'b11, then released -> all outputs 0 during reset. o_debounced=2'b11 and o_rise=2'b11 on the 3rd edge after i_rst falls; one-cycle pulse only.
- Ch0 press, then a 2-cycle low glitch starting 1 cycle after acceptance -> o_debounced[0] stays 1, no o_fall. Release 8 cycles later -> o_fall[0] pulse 3 edges after release.
- Ch0 held 30 cycles -> o_long[0] exactly 10 cycles after o_rise[0]. o_repeat[0] pulses at +3, +6, +9 … cycles after o_long, all single-cycle.
- Ch0 released at cycle 9 after o_rise (accepted at hold=9) -> no o_long; re-press yields a fresh count and o_long 10 cycles after the new o_rise.
- i_tick pulsed 1 cycle in 4 -> lockout and long-press durations scale ×4. Ch1 toggling meanwhile does not disturb ch0 counts.
- Assert i_rst for 1 cycle during ch1 lockout and hold -> next cycle all ch1 state is 0. If still held, o_rise[1] fires again 3 edges after reset and o_long[1] is re-timed from it.
